multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multicycle control unit for the CPU datapath. It walks each instruction through IF/ID/EXE/MEM/WB states and drives the next-PC select code (`PCSrc`) and `PCWre` consumed by the PC address mux and PC register. It also drives every datapath write-enable and select.

## Interface
- No parameters.
- `CLK`  in  1  rising-edge clock
- `Reset`  in  1  synchronous, active-high reset
- `opcode`  in  6  `IR[31:26]`, valid from `sID` onward
- `zero`  in  1  ALU result == 0
- `sign`  in  1  ALU result[31]
- `state`  out  3  current state code
- `PCWre`  out  1  PC register load enable
- `PCSrc`  out  2  next PC select: 00 = PC+4, 01 = PC+4+(sext(imm)<<2), 10 = rs, 11 = jump target
- `IRWre`  out  1  instruction register load
- `RegWre`  out  1  register file write
- `RegDst`  out  2  write register select: 00 = $31, 01 = rt, 10 = rd
- `WrRegDSrc`  out  1  write data select: 0 = PC+4, 1 = DB
- `ALUSrcA`  out  1  ALU A select: 1 = sa, 0 = rs
- `ALUSrcB`  out  1  ALU B select: 1 = ext(imm), 0 = rt
- `ALUOp`  out  3  ALU op: 000 add, 001 sub, 010 sll, 011 or, 100 and, 101 sltu, 110 slt
- `ExtSel`  out  1  immediate extend: 1 = sign, 0 = zero
- `mRD`  out  1  data memory read
- `mWR`  out  1  data memory write
- `DBDataSrc`  out  1  DB select: 1 = memory, 0 = ALU
- `halted`  out  1  processor stopped on halt

## Operation
- State register, 3 bits. Codes: `sIF` = 000, `sID` = 001, `sEXE_LS` = 010, `sMEM` = 011, `sWB_LD` = 100, `sEXE_BR` = 101, `sEXE_AL` = 110, `sWB_AL` = 111.
- All outputs are decoded combinationally from `state`, `opcode`, `zero` and `sign`.
- Opcodes:
  - ALU class: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sltiu 100111
  - Memory: sw 110000, lw 110001
  - Branch: beq 110100, bltz 110110
  - Jump: j 111000, jr 111001, jal 111010
  - halt 111111
- Transitions:
  - `sIF` → `sID`.
  - `sID` → `sEXE_AL` (ALU class), `sEXE_LS` (sw/lw), `sEXE_BR` (beq/bltz), `sIF` (j/jr/jal/illegal).
  - `sID` stays in `sID` on halt.
  - `sEXE_AL` → `sWB_AL` → `sIF`.
  - `sEXE_LS` → `sMEM`.
  - `sMEM` → `sIF` (sw) or `sWB_LD` (lw).
  - `sWB_LD` → `sIF`.
  - `sEXE_BR` → `sIF`.
- `IRWre` = 1 only in `sIF`.
- `PCWre` = 1 only in the final state of each instruction:
  - `sID` for j/jr/jal/illegal
  - `sEXE_BR`
  - `sMEM` for sw
  - `sWB_AL`
  - `sWB_LD`
- `PCSrc` is 00 whenever `PCWre` = 0. When `PCWre` = 1:
  - j/jal → 11
  - jr → 10
  - beq → 01 if `zero`, else 00
  - bltz → 01 if `sign`, else 00
  - all others → 00
- `RegWre` = 1 only in `sWB_AL`, `sWB_LD`, and `sID` for jal.
  - jal: `RegDst` = 00, `WrRegDSrc` = 0.
  - R-type writes: `RegDst` = 10.
  - Immediate and lw writes: `RegDst` = 01.
- `mWR` = 1 only in `sMEM` for sw. `mRD` = 1 in `sMEM` and `sWB_LD` for lw.
- `ALUSrcB` = 1 for addi/ori/sltiu/sw/lw. `ALUSrcA` = 1 for sll.
- `ExtSel` = 0 for ori/sltiu, else 1.
- beq uses sub; bltz uses add with B = $0.
- Illegal opcode executes as a 2-cycle nop: `PCWre` = 1 and `PCSrc` = 00 in `sID`; no writes.
- `halted` = (`state` == `sID` && opcode == halt). Halt holds `PCWre` = 0 and `IRWre` = 0, so state self-loops until `Reset`.

## Timing
- `Reset` sampled high at a `CLK` edge forces `state` = `sIF`.
- While `Reset` = 1, every enable is forced low: `PCWre`, `IRWre`, `RegWre`, `mWR`, `mRD`. `PCSrc` = 00, `halted` = 0.
- Reset mid-instruction abandons it with no further writes.
- Cycles per instruction: j/jr/jal = 2, beq/bltz = 3, ALU class = 4, sw = 4, lw = 5.
- The PC and IR load at the `CLK` edge that ends the asserting cycle.
- `zero` and `sign` are sampled combinationally in `sEXE_BR` and must be stable before that cycle's edge.

## Configuration
- `CTRL_JAL_EN` defined: jal behaves as above (writes PC+4 to $31, then jumps).
- `CTRL_JAL_EN` undefined: opcode 111010 decodes as illegal (2-cycle nop, `PCSrc` = 00, no register write).

## Test plan
- Reset held 2 cycles, then released → `state` = 000, all enables 0 during reset. First post-reset cycle shows `IRWre` = 1 and `PCWre` = 0.
- add (000000) → states 000, 001, 110, 111. In state 111: `RegWre` = 1, `RegDst` = 10, `PCWre` = 1, `PCSrc` = 00.
- lw (110001) → 5 cycles, `mRD` = 1 in 011/100, `DBDataSrc` = 1, `RegDst` = 01.
  - sw (110000) → `mWR` = 1 only in 011, then 000.
- beq with `zero` = 1 → `PCSrc` = 01 in 101. With `zero` = 0 → 00.
  - bltz with `sign` = 1 → 01.
- j → `PCSrc` = 11 in 001; jr → 10.
  - jal: `RegWre` = 1, `RegDst` = 00 with `CTRL_JAL_EN`; no write and `PCSrc` = 00 without it.
- halt (111111) → `halted` = 1, `state` stays 001 for 10 cycles with `PCWre` = 0. `Reset` → `state` 000.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the CPU datapath.
// master = control unit side, slave = datapath side.
interface multicycle_control_fsm_if;
   logic [5:0] opcode;
   logic       zero;
   logic       sign;
   logic [2:0] state;
   logic       PCWre;
   logic [1:0] PCSrc;
   logic       IRWre;
   logic       RegWre;
   logic [1:0] RegDst;
   logic       WrRegDSrc;
   logic       ALUSrcA;
   logic       ALUSrcB;
   logic [2:0] ALUOp;
   logic       ExtSel;
   logic       mRD;
   logic       mWR;
   logic       DBDataSrc;
   logic       halted;

   modport master (
      input  opcode, zero, sign,
      output state, PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc,
             ALUSrcA, ALUSrcB, ALUOp, ExtSel, mRD, mWR, DBDataSrc, halted
   );

   modport slave (
      output opcode, zero, sign,
      input  state, PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc,
             ALUSrcA, ALUSrcB, ALUOp, ExtSel, mRD, mWR, DBDataSrc, halted
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control unit: IF/ID/EXE/MEM/WB sequencing plus datapath selects.
// Define CTRL_JAL_EN to enable jal (link to $31 and jump); otherwise 111010 is an illegal nop.
module multicycle_control_fsm (
   input  logic                           CLK,
   input  logic                           Reset,
   multicycle_control_fsm_if.master       bus
);
   typedef enum logic [2:0] {
      sIF     = 3'b000,
      sID     = 3'b001,
      sEXE_LS = 3'b010,
      sMEM    = 3'b011,
      sWB_LD  = 3'b100,
      sEXE_BR = 3'b101,
      sEXE_AL = 3'b110,
      sWB_AL  = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDI  = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b010000;
   localparam logic [5:0] OP_AND   = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTIU = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   state_t state_q, state_d;

   logic is_alu, is_rtype, is_imm, is_sw, is_lw, is_beq, is_bltz;
   logic is_j, is_jr, is_jal, is_halt;
   logic [2:0] alu_op;

   // Instruction class decode; anything not listed is an illegal 2-cycle nop.
   always_comb begin
      is_alu   = 1'b0;
      is_rtype = 1'b0;
      is_imm   = 1'b0;
      is_sw    = 1'b0;
      is_lw    = 1'b0;
      is_beq   = 1'b0;
      is_bltz  = 1'b0;
      is_j     = 1'b0;
      is_jr    = 1'b0;
      is_jal   = 1'b0;
      is_halt  = 1'b0;
      alu_op   = 3'b000;
      case (bus.opcode)
         OP_ADD:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = 3'b000; end
         OP_SUB:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = 3'b001; end
         OP_ADDI:  begin is_alu = 1'b1; is_imm   = 1'b1; alu_op = 3'b000; end
         OP_OR:    begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = 3'b011; end
         OP_AND:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = 3'b100; end
         OP_ORI:   begin is_alu = 1'b1; is_imm   = 1'b1; alu_op = 3'b011; end
         OP_SLL:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = 3'b010; end
         OP_SLT:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = 3'b110; end
         OP_SLTIU: begin is_alu = 1'b1; is_imm   = 1'b1; alu_op = 3'b101; end
         OP_SW:    is_sw = 1'b1;
         OP_LW:    is_lw = 1'b1;
         OP_BEQ:   begin is_beq = 1'b1; alu_op = 3'b001; end
         OP_BLTZ:  is_bltz = 1'b1;
         OP_J:     is_j = 1'b1;
         OP_JR:    is_jr = 1'b1;
`ifdef CTRL_JAL_EN
         OP_JAL:   is_jal = 1'b1;
`else
         OP_JAL:   is_jal = 1'b0;
`endif
         OP_HALT:  is_halt = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) state_q <= sIF;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         sIF:     state_d = sID;
         sID: begin
            if (is_halt)              state_d = sID;
            else if (is_alu)          state_d = sEXE_AL;
            else if (is_sw || is_lw)  state_d = sEXE_LS;
            else if (is_beq || is_bltz) state_d = sEXE_BR;
            else                      state_d = sIF;
         end
         sEXE_AL: state_d = sWB_AL;
         sWB_AL:  state_d = sIF;
         sEXE_LS: state_d = sMEM;
         sMEM:    state_d = is_lw ? sWB_LD : sIF;
         sWB_LD:  state_d = sIF;
         sEXE_BR: state_d = sIF;
         default: state_d = sIF;
      endcase
   end

   logic pc_wre;

   always_comb begin
      bus.state     = state_q;
      bus.IRWre     = 1'b0;
      bus.RegWre    = 1'b0;
      bus.mWR       = 1'b0;
      bus.mRD       = 1'b0;
      bus.PCSrc     = 2'b00;
      bus.halted    = 1'b0;
      bus.RegDst    = is_jal ? 2'b00 : (is_rtype ? 2'b10 : 2'b01);
      bus.WrRegDSrc = ~is_jal;
      bus.ALUSrcA   = (bus.opcode == OP_SLL);
      bus.ALUSrcB   = is_imm | is_sw | is_lw;
      bus.ALUOp     = alu_op;
      bus.ExtSel    = ~((bus.opcode == OP_ORI) | (bus.opcode == OP_SLTIU));
      bus.DBDataSrc = is_lw;

      // Final cycle of each instruction loads the PC; sMEM only ends non-lw.
      pc_wre = 1'b0;
      case (state_q)
         sID:     pc_wre = ~(is_alu | is_sw | is_lw | is_beq | is_bltz | is_halt);
         sEXE_BR: pc_wre = 1'b1;
         sMEM:    pc_wre = ~is_lw;
         sWB_AL:  pc_wre = 1'b1;
         sWB_LD:  pc_wre = 1'b1;
         default: pc_wre = 1'b0;
      endcase

      if (!Reset) begin
         bus.IRWre  = (state_q == sIF);
         bus.RegWre = (state_q == sWB_AL) || (state_q == sWB_LD) ||
                      ((state_q == sID) && is_jal);
         bus.mWR    = (state_q == sMEM) && is_sw;
         bus.mRD    = ((state_q == sMEM) || (state_q == sWB_LD)) && is_lw;
         bus.halted = (state_q == sID) && is_halt;
         if (pc_wre) begin
            if (is_j || is_jal)                 bus.PCSrc = 2'b11;
            else if (is_jr)                     bus.PCSrc = 2'b10;
            else if (is_beq && bus.zero)        bus.PCSrc = 2'b01;
            else if (is_bltz && bus.sign)       bus.PCSrc = 2'b01;
            else                                bus.PCSrc = 2'b00;
         end
      end
      bus.PCWre = pc_wre & ~Reset;
   end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// cycle by cycle and compares control outputs against hand-computed values.
module tb_multicycle_control_fsm;
   logic CLK;
   logic Reset;
   int   checks;
   int   failures;

   multicycle_control_fsm_if bus ();

   multicycle_control_fsm dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Check state, PCWre, PCSrc, IRWre, RegWre, mRD, mWR, halted this cycle, then advance.
   task automatic cyc(input string tag, input logic [2:0] st, input logic pw,
                      input logic [1:0] ps, input logic ir, input logic rw,
                      input logic rd, input logic wr, input logic h);
      chk({tag, ".state"}, 32'(bus.state), 32'(st));
      chk({tag, ".ctl"},
          32'({bus.PCWre, bus.PCSrc, bus.IRWre, bus.RegWre, bus.mRD, bus.mWR, bus.halted}),
          32'({pw, ps, ir, rw, rd, wr, h}));
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      Reset    = 1'b1;
      bus.opcode = 6'b000000;
      bus.zero   = 1'b0;
      bus.sign   = 1'b0;

      step();
      step();
      chk("rst.state", 32'(bus.state), 32'd0);
      chk("rst.enables",
          32'({bus.PCWre, bus.IRWre, bus.RegWre, bus.mWR, bus.mRD, bus.halted}), 32'd0);
      chk("rst.pcsrc", 32'(bus.PCSrc), 32'd0);
      Reset = 1'b0;
      #1;

      // add
      bus.opcode = 6'b000000;
      cyc("add.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("add.id",  3'd1, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("add.aluop", 32'(bus.ALUOp), 32'd0);
      cyc("add.exe", 3'd6, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("add.regdst", 32'(bus.RegDst), 32'd2);
      chk("add.wrsrc", 32'(bus.WrRegDSrc), 32'd1);
      cyc("add.wb",  3'd7, 1, 2'b00, 0, 1, 0, 0, 0);

      // ori: zero-extend immediate, write rt
      bus.opcode = 6'b010010;
      cyc("ori.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("ori.id",  3'd1, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("ori.sel", 32'({bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.ALUOp}), 32'b0_1_0_011);
      cyc("ori.exe", 3'd6, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("ori.regdst", 32'(bus.RegDst), 32'd1);
      cyc("ori.wb",  3'd7, 1, 2'b00, 0, 1, 0, 0, 0);

      // sll: A = sa
      bus.opcode = 6'b011000;
      cyc("sll.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("sll.id",  3'd1, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("sll.sel", 32'({bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.ALUOp}), 32'b1_0_1_010);
      cyc("sll.exe", 3'd6, 0, 2'b00, 0, 0, 0, 0, 0);
      cyc("sll.wb",  3'd7, 1, 2'b00, 0, 1, 0, 0, 0);

      // lw
      bus.opcode = 6'b110001;
      cyc("lw.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("lw.id",  3'd1, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("lw.srcb", 32'(bus.ALUSrcB), 32'd1);
      cyc("lw.exe", 3'd2, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("lw.dbsrc", 32'(bus.DBDataSrc), 32'd1);
      cyc("lw.mem", 3'd3, 0, 2'b00, 0, 0, 1, 0, 0);
      chk("lw.regdst", 32'(bus.RegDst), 32'd1);
      cyc("lw.wb",  3'd4, 1, 2'b00, 0, 1, 1, 0, 0);

      // sw
      bus.opcode = 6'b110000;
      cyc("sw.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("sw.id",  3'd1, 0, 2'b00, 0, 0, 0, 0, 0);
      cyc("sw.exe", 3'd2, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("sw.dbsrc", 32'(bus.DBDataSrc), 32'd0);
      cyc("sw.mem", 3'd3, 1, 2'b00, 0, 0, 0, 1, 0);

      // beq taken
      bus.opcode = 6'b110100;
      bus.zero   = 1'b1;
      cyc("beq1.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("beq1.id",  3'd1, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("beq.alu", 32'({bus.ALUSrcB, bus.ALUOp}), 32'b0_001);
      cyc("beq1.br",  3'd5, 1, 2'b01, 0, 0, 0, 0, 0);

      // beq not taken
      bus.zero = 1'b0;
      cyc("beq0.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("beq0.id",  3'd1, 0, 2'b00, 0, 0, 0, 0, 0);
      cyc("beq0.br",  3'd5, 1, 2'b00, 0, 0, 0, 0, 0);

      // bltz taken
      bus.opcode = 6'b110110;
      bus.sign   = 1'b1;
      cyc("bltz.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("bltz.id",  3'd1, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("bltz.alu", 32'({bus.ALUSrcB, bus.ALUOp}), 32'b0_000);
      cyc("bltz.br",  3'd5, 1, 2'b01, 0, 0, 0, 0, 0);
      bus.sign = 1'b0;

      // j, jr
      bus.opcode = 6'b111000;
      cyc("j.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("j.id",  3'd1, 1, 2'b11, 0, 0, 0, 0, 0);
      bus.opcode = 6'b111001;
      cyc("jr.if", 3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("jr.id", 3'd1, 1, 2'b10, 0, 0, 0, 0, 0);

      // jal
      bus.opcode = 6'b111010;
      cyc("jal.if", 3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
`ifdef CTRL_JAL_EN
      chk("jal.sel", 32'({bus.RegDst, bus.WrRegDSrc}), 32'b00_0);
      cyc("jal.id", 3'd1, 1, 2'b11, 0, 1, 0, 0, 0);
`else
      cyc("jal.id", 3'd1, 1, 2'b00, 0, 0, 0, 0, 0);
`endif

      // illegal opcode: 2-cycle nop
      bus.opcode = 6'b101010;
      cyc("ill.if", 3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("ill.id", 3'd1, 1, 2'b00, 0, 0, 0, 0, 0);

      // reset in the middle of lw abandons it
      bus.opcode = 6'b110001;
      cyc("lwr.if",  3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      cyc("lwr.id",  3'd1, 0, 2'b00, 0, 0, 0, 0, 0);
      cyc("lwr.exe", 3'd2, 0, 2'b00, 0, 0, 0, 0, 0);
      Reset = 1'b1;
      #1;
      chk("lwr.rst_mem", 32'({bus.state, bus.PCWre, bus.mRD, bus.RegWre}), 32'({3'd3, 3'b000}));
      step();
      chk("lwr.rst_state", 32'(bus.state), 32'd0);
      Reset = 1'b0;
      #1;

      // halt: parks in sID
      bus.opcode = 6'b111111;
      cyc("halt.if", 3'd0, 0, 2'b00, 1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         cyc($sformatf("halt.c%0d", i), 3'd1, 0, 2'b00, 0, 0, 0, 0, 1);
      Reset = 1'b1;
      #1;
      chk("halt.rst_halted", 32'(bus.halted), 32'd0);
      step();
      chk("halt.rst_state", 32'(bus.state), 32'd0);
      Reset = 1'b0;
      #1;
      chk("post.irwre", 32'({bus.IRWre, bus.PCWre}), 32'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
